// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request picker. MEM_ARB_FAIR_EN selects round-robin; otherwise DMA has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_owner,
  output logic grant
);

`ifdef MEM_ARB_FAIR_EN
  always_comb begin
    // On contention hand the port to whoever did not have it last.
    if (cpu_req && dma_req) grant = ~last_owner;
    else                    grant = dma_req ? OWN_DMA : OWN_CPU;
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    grant = dma_req ? OWN_DMA : OWN_CPU;
  end
`endif

endmodule

// File: rtl/mem_port_arb.sv
// Shares one memory port between the CPU and a DMA/debug loader; one access at a time, read latency MEM_LAT.
// Arbitration policy is chosen by the MEM_ARB_FAIR_EN macro (see mem_arb_pick).
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [1:0]    cpu_size,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_adr,
  input  logic [DW-1:0] dma_wdata,
  input  logic [1:0]    dma_size,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_size,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  state_t           state, state_n;
  logic [LAT_W-1:0] cnt;
  logic             own_q, we_q, last_owner;
  logic             grant, latch_en, capture;

  mem_arb_pick u_pick (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .last_owner (last_owner),
    .grant      (grant)
  );

  // NOTE: sequential state is written only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    // NOTE: defaults first, so no branch leaves a variable unassigned and no latch is inferred.
    state_n  = state;
    latch_en = 1'b0;
    capture  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          latch_en = 1'b1;
          state_n  = ST_ACCESS;
        end
      end
      ST_ACCESS: state_n = we_q ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (cnt == LAT_W'(1)) begin
          capture = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Counter holds MEM_LAT on the first WAIT cycle and hits 1 on the rdata-valid cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt <= '0;
    else if (state == ST_ACCESS) cnt <= LAT_W'(MEM_LAT);
    else if (state == ST_WAIT)   cnt <= cnt - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q     <= OWN_CPU;
      we_q      <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      mem_size  <= SZ_WORD;
    end else if (latch_en) begin
      own_q     <= grant;
      we_q      <= (grant == OWN_DMA) ? dma_we    : cpu_we;
      mem_adr   <= (grant == OWN_DMA) ? dma_adr   : cpu_adr;
      mem_wdata <= (grant == OWN_DMA) ? dma_wdata : cpu_wdata;
      mem_size  <= (grant == OWN_DMA) ? dma_size  : cpu_size;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      last_owner <= OWN_DMA;
    end else begin
      if (capture && own_q == OWN_CPU) cpu_rdata <= mem_rdata;
      if (capture && own_q == OWN_DMA) dma_rdata <= mem_rdata;
      if (state == ST_DONE)            last_owner <= own_q;
    end
  end

  // Strobes are decoded from state, so an asynchronous reset removes them at once.
  assign mem_en    = (state == ST_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign cpu_ack   = (state == ST_DONE) && (own_q == OWN_CPU);
  assign dma_ack   = (state == ST_DONE) && (own_q == OWN_DMA);
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign owner     = own_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: one MEM_LAT=1 instance with a scoreboard, one MEM_LAT=4 instance.
module tb_mem_port_arb;
  import mem_arb_pkg::*;

  typedef struct {
    logic        own;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
  logic [1:0]  cpu_size;
  logic        dma_req, dma_we, dma_ack;
  logic [31:0] dma_adr, dma_wdata, dma_rdata;
  logic [1:0]  dma_size;
  logic        mem_en, mem_we, owner, busy;
  logic [31:0] mem_adr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  logic        cpu_req_4, cpu_we_4, cpu_ack_4, cpu_stall_4;
  logic [31:0] cpu_adr_4, cpu_wdata_4, cpu_rdata_4;
  logic [1:0]  cpu_size_4;
  logic        dma_req_4, dma_we_4, dma_ack_4;
  logic [31:0] dma_adr_4, dma_wdata_4, dma_rdata_4;
  logic [1:0]  dma_size_4;
  logic        mem_en_4, mem_we_4, owner_4, busy_4;
  logic [31:0] mem_adr_4, mem_wdata_4, mem_rdata_4;
  logic [1:0]  mem_size_4;

  mem_port_arb #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
    .dma_size(dma_size), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
  );

  mem_port_arb #(.AW(32), .DW(32), .MEM_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req_4), .cpu_we(cpu_we_4), .cpu_adr(cpu_adr_4), .cpu_wdata(cpu_wdata_4),
    .cpu_size(cpu_size_4), .cpu_rdata(cpu_rdata_4), .cpu_ack(cpu_ack_4), .cpu_stall(cpu_stall_4),
    .dma_req(dma_req_4), .dma_we(dma_we_4), .dma_adr(dma_adr_4), .dma_wdata(dma_wdata_4),
    .dma_size(dma_size_4), .dma_rdata(dma_rdata_4), .dma_ack(dma_ack_4),
    .mem_en(mem_en_4), .mem_we(mem_we_4), .mem_adr(mem_adr_4), .mem_wdata(mem_wdata_4),
    .mem_size(mem_size_4), .mem_rdata(mem_rdata_4), .owner(owner_4), .busy(busy_4)
  );

  int   checks = 0;
  int   errors = 0;
  int   n_cpu_ack = 0;
  int   n_dma_ack = 0;
  int   nc, nd, dma_ack_before;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic push_exp(input logic own, input logic we, input logic [31:0] adr,
                          input logic [31:0] wdata, input logic [1:0] size);
    exp_t e;
    e.own = own; e.we = we; e.adr = adr; e.wdata = wdata; e.size = size;
    exp_q.push_back(e);
  endtask

  // Every memory strobe of the MEM_LAT=1 instance must match the next queued access.
  always @(negedge clk) begin
    if (cpu_ack || dma_ack) begin
      check("ack exclusive", 32'(cpu_ack & dma_ack), 32'd0);
      n_cpu_ack += int'(cpu_ack);
      n_dma_ack += int'(dma_ack);
    end
    if (mem_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected mem_en", 32'(mem_en), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb owner", 32'(owner), 32'(mon_e.own));
        check("sb mem_we", 32'(mem_we), 32'(mon_e.we));
        check("sb mem_adr", mem_adr, mon_e.adr);
        check("sb mem_size", 32'(mem_size), 32'(mon_e.size));
        if (mon_e.we) check("sb mem_wdata", mem_wdata, mon_e.wdata);
      end
    end
  end

  // Runs one MEM_LAT=4 CPU read from cycle 0 (request already high) through the idle cycle after ack.
  task automatic run_lat4(input logic [31:0] data, input logic [31:0] prior);
    mem_rdata_4 = '1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("lat4 mem_en c%0d", c), 32'(mem_en_4), 32'(c == 1));
      check($sformatf("lat4 busy c%0d", c), 32'(busy_4), 32'(c >= 1 && c <= 6));
      check($sformatf("lat4 cpu_ack c%0d", c), 32'(cpu_ack_4), 32'(c == 6));
      check($sformatf("lat4 stall c%0d", c), 32'(cpu_stall_4), 32'(c < 6));
      check($sformatf("lat4 cpu_rdata c%0d", c), cpu_rdata_4, (c >= 6) ? data : prior);
      if (c == 6) cpu_req_4 = 1'b0;
      @(posedge clk); #1;
      if (c == 4) mem_rdata_4 = data;
      if (c == 5) mem_rdata_4 = '1;
    end
  endtask

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_wdata = 0; cpu_size = SZ_WORD;
    dma_req = 0; dma_we = 0; dma_adr = 0; dma_wdata = 0; dma_size = SZ_WORD;
    mem_rdata = 0;
    cpu_req_4 = 0; cpu_we_4 = 0; cpu_adr_4 = 0; cpu_wdata_4 = 0; cpu_size_4 = SZ_WORD;
    dma_req_4 = 0; dma_we_4 = 0; dma_adr_4 = 0; dma_wdata_4 = 0; dma_size_4 = SZ_WORD;
    mem_rdata_4 = 0;

    #1 rst = 1'b1;
    #1;
    check("rst mem_en", 32'(mem_en), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst owner", 32'(owner), 32'd0);
    check("rst cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst dma_ack", 32'(dma_ack), 32'd0);
    check("rst mem_adr", mem_adr, 32'd0);
    check("rst cpu_rdata", cpu_rdata, 32'd0);
    check("rst dma_rdata", dma_rdata, 32'd0);
    check("rst busy4", 32'(busy_4), 32'd0);

    // CPU read, MEM_LAT=1
    @(posedge clk); #1;
    rst = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_adr = 32'h10; cpu_size = SZ_WORD;
    push_exp(OWN_CPU, 1'b0, 32'h10, 32'h0, SZ_WORD);
    @(negedge clk);
    check("t1 stall c0", 32'(cpu_stall), 32'd1);
    check("t1 busy c0", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1 mem_en c1", 32'(mem_en), 32'd1);
    check("t1 mem_we c1", 32'(mem_we), 32'd0);
    check("t1 mem_adr c1", mem_adr, 32'h10);
    check("t1 stall c1", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    check("t1 mem_en c2", 32'(mem_en), 32'd0);
    check("t1 cpu_ack c2", 32'(cpu_ack), 32'd0);
    check("t1 stall c2", 32'(cpu_stall), 32'd1);
    @(posedge clk); #1;
    mem_rdata = 32'h0;
    @(negedge clk);
    check("t1 cpu_ack c3", 32'(cpu_ack), 32'd1);
    check("t1 stall c3", 32'(cpu_stall), 32'd0);
    check("t1 cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("t1 dma_ack c3", 32'(dma_ack), 32'd0);
    check("t1 dma_rdata", dma_rdata, 32'h0);
    cpu_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t1 cpu_ack c4", 32'(cpu_ack), 32'd0);
    check("t1 busy c4", 32'(busy), 32'd0);
    check("t1 mem_adr held", mem_adr, 32'h10);

    // DMA byte write
    @(posedge clk); #1;
    dma_req = 1; dma_we = 1; dma_adr = 32'h40; dma_wdata = 32'h12345678; dma_size = SZ_BYTE;
    push_exp(OWN_DMA, 1'b1, 32'h40, 32'h12345678, SZ_BYTE);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2 mem_en c1", 32'(mem_en), 32'd1);
    check("t2 mem_we c1", 32'(mem_we), 32'd1);
    check("t2 mem_size c1", 32'(mem_size), 32'(SZ_BYTE));
    @(posedge clk); #1;
    @(negedge clk);
    check("t2 dma_ack c2", 32'(dma_ack), 32'd1);
    check("t2 cpu_ack c2", 32'(cpu_ack), 32'd0);
    check("t2 cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    check("t2 dma_rdata", dma_rdata, 32'h0);
    dma_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t2 busy c3", 32'(busy), 32'd0);
    check("t2 mem_we c3", 32'(mem_we), 32'd0);
    check("t2 mem_wdata held", mem_wdata, 32'h12345678);

    // One-cycle DMA request while the CPU owns the port
    @(posedge clk); #1;
    dma_ack_before = n_dma_ack;
    cpu_req = 1; cpu_we = 0; cpu_adr = 32'h30; cpu_size = SZ_HALF;
    mem_rdata = 32'h55AA55AA;
    push_exp(OWN_CPU, 1'b0, 32'h30, 32'h0, SZ_HALF);
    @(posedge clk); #1;
    dma_req = 1; dma_we = 0; dma_adr = 32'h80;
    @(posedge clk); #1;
    dma_req = 0;
    @(posedge clk); #1;
    @(negedge clk);
    check("t6 cpu_ack c3", 32'(cpu_ack), 32'd1);
    check("t6 cpu_rdata", cpu_rdata, 32'h55AA55AA);
    cpu_req = 0;
    repeat (6) @(posedge clk);
    #1;
    check("t6 no dma_ack", 32'(n_dma_ack), 32'(dma_ack_before));
    check("t6 queue drained", 32'(exp_q.size()), 32'd0);
    check("t6 dma_rdata", dma_rdata, 32'h0);

    // Both requesters held from reset release, four writes each
    rst = 1'b1;
    #1;
    cpu_req = 1; cpu_we = 1; cpu_adr = 32'h100; cpu_wdata = 32'hC000_0100; cpu_size = SZ_WORD;
    dma_req = 1; dma_we = 1; dma_adr = 32'h200; dma_wdata = 32'hD000_0200; dma_size = SZ_WORD;
`ifdef MEM_ARB_FAIR_EN
    for (int k = 0; k < 4; k++) begin
      push_exp(OWN_CPU, 1'b1, 32'h100 + 32'(4 * k), 32'hC000_0100 + 32'(4 * k), SZ_WORD);
      push_exp(OWN_DMA, 1'b1, 32'h200 + 32'(4 * k), 32'hD000_0200 + 32'(4 * k), SZ_WORD);
    end
`else
    for (int k = 0; k < 4; k++)
      push_exp(OWN_DMA, 1'b1, 32'h200 + 32'(4 * k), 32'hD000_0200 + 32'(4 * k), SZ_WORD);
    for (int k = 0; k < 4; k++)
      push_exp(OWN_CPU, 1'b1, 32'h100 + 32'(4 * k), 32'hC000_0100 + 32'(4 * k), SZ_WORD);
`endif
    nc = 0; nd = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int cyc = 0; cyc < 200 && (nc < 4 || nd < 4); cyc++) begin
      @(negedge clk);
      if (cpu_ack) begin
        nc++;
        if (nc == 4) cpu_req = 0;
        else begin
          cpu_adr   = 32'h100 + 32'(4 * nc);
          cpu_wdata = 32'hC000_0100 + 32'(4 * nc);
        end
      end
      if (dma_ack) begin
        nd++;
        if (nd == 4) dma_req = 0;
        else begin
          dma_adr   = 32'h200 + 32'(4 * nd);
          dma_wdata = 32'hD000_0200 + 32'(4 * nd);
        end
      end
    end
    check("t3 cpu acks", 32'(nc), 32'd4);
    check("t3 dma acks", 32'(nd), 32'd4);
    check("t3 queue drained", 32'(exp_q.size()), 32'd0);

    // MEM_LAT=4 CPU read
    @(posedge clk); #1;
    cpu_req_4 = 1; cpu_we_4 = 0; cpu_adr_4 = 32'h20; cpu_size_4 = SZ_WORD;
    run_lat4(32'hCAFEF00D, 32'h0);

    // Reset in cycle 2 of a MEM_LAT=4 read, then a fresh read
    @(posedge clk); #1;
    cpu_req_4 = 1; cpu_adr_4 = 32'h24;
    mem_rdata_4 = '1;
    @(negedge clk);
    check("t5 busy c0", 32'(busy_4), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5 mem_en c1", 32'(mem_en_4), 32'd1);
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("t5 rst busy", 32'(busy_4), 32'd0);
    check("t5 rst mem_en", 32'(mem_en_4), 32'd0);
    check("t5 rst cpu_ack", 32'(cpu_ack_4), 32'd0);
    check("t5 rst cpu_rdata", cpu_rdata_4, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_lat4(32'h0BADC0DE, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
